// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the FIFO read-side controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: rd_state_t (read scheduler FSM states), default parameter
// widths, and blen_eff(), which maps a zero burst length to one word.
package fifo_ctrl_pkg;

    localparam int DSIZE_DEF  = 8;
    localparam int ASIZE_DEF  = 4;
    localparam int BLEN_W_DEF = 5;
    localparam int TMO_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_BURST      = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_FLUSH_WAIT = 2'd3
    } rd_state_t;

    // A programmed length of zero would never terminate a burst on count,
    // so it is treated as a single-word burst.
    function automatic logic [31:0] blen_eff(input logic [31:0] blen);
        return (blen == 32'd0) ? 32'd1 : blen;
    endfunction

endpackage

// File: rtl/rd_tmo_cnt.sv
// Saturating idle counter that flags when a partial-drain timeout expires.
// Latency: count advances one per enabled cycle; o_hit is combinational on the count.
// Backpressure: none; i_clr has priority over i_en.
//
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_clr            clear count to zero
//   i_en             advance count (holds at all-ones)
//   i_cfg_tmo        compare value; zero disables o_hit
//   o_hit            count equals i_cfg_tmo and i_cfg_tmo is non-zero
module rd_tmo_cnt #(
    parameter int TMO_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [TMO_W-1:0] i_cfg_tmo,
    output logic             o_hit
);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (i_cfg_tmo != '0) && (r_cnt == i_cfg_tmo);

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side burst scheduler: pops the async FIFO in bursts into a one-entry output register.
// Latency: first pop one cycle after the open condition; m_valid rises on the popping edge.
// Backpressure: m_ready low with m_valid high blocks rinc combinationally; 1 word/cycle otherwise.
//
// Optional feature macro: FIFO_RD_CTRL_STATS_EN adds stat_words (pop count,
// wraps) and stat_uflow (underflow count, saturates); both clear on flush.
//
// Ports:
//   rclk, rrst_n                 read clock, synchronous active-low reset
//   empty, near_empty, under_flow  registered FIFO status
//   rdata                        FIFO word at the read address (valid when !empty)
//   rinc                         pop strobe (combinational)
//   rptr_clr, flush_done         flush sequencing outputs (registered)
//   near_empty_mrgn              registered copy of cfg_mrgn
//   cfg_mrgn, cfg_blen, cfg_tmo  margin, burst length, partial-drain timeout
//   flush_req                    flush request pulse
//   m_valid, m_ready, m_data     consumer handshake
//   busy, err                    not-idle indication, sticky underflow
module fifo_rd_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DSIZE  = DSIZE_DEF,
    parameter int ASIZE  = ASIZE_DEF,
    parameter int BLEN_W = BLEN_W_DEF,
    parameter int TMO_W  = TMO_W_DEF
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              empty,
    input  logic              near_empty,
    input  logic              under_flow,
    input  logic [DSIZE-1:0]  rdata,
    output logic              rinc,
    output logic              rptr_clr,
    output logic [ASIZE:0]    near_empty_mrgn,
    input  logic [ASIZE:0]    cfg_mrgn,
    input  logic [BLEN_W-1:0] cfg_blen,
    input  logic [TMO_W-1:0]  cfg_tmo,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DSIZE-1:0]  m_data,
    output logic              busy,
    output logic              err
`ifdef FIFO_RD_CTRL_STATS_EN
   ,output logic [31:0]       stat_words,
    output logic [15:0]       stat_uflow
`endif
);

    rd_state_t         r_state;
    logic [BLEN_W-1:0] r_bcnt;
    logic [BLEN_W-1:0] r_blen;
    logic [DSIZE-1:0]  r_m_data;
    logic              r_m_valid;
    logic              r_rptr_clr;
    logic              r_flush_done;
    logic              r_err;
    logic [ASIZE:0]    r_mrgn;

    logic              w_rinc;
    logic              w_idle_go;
    logic              w_tmo_en;
    logic              w_tmo_clr;
    logic              w_tmo_hit;
    logic [BLEN_W-1:0] w_bcnt_nxt;
    logic              w_burst_last;

    // Pop only when the output register is free or being drained this cycle.
    // A flush request in the same cycle suppresses the pop.
    assign w_rinc = (r_state == ST_BURST) & ~empty & (~r_m_valid | m_ready) & ~flush_req;

    // Healthy occupancy, or a partial drain once the FIFO has sat non-empty
    // for cfg_tmo cycles.
    assign w_idle_go = (r_state == ST_IDLE) & ~empty & (~near_empty | w_tmo_hit) & ~flush_req;

    assign w_tmo_en  = (r_state == ST_IDLE) & ~empty;
    assign w_tmo_clr = (r_state != ST_IDLE) | empty | flush_req | w_idle_go;

    assign w_bcnt_nxt   = r_bcnt + 1'b1;
    assign w_burst_last = (w_bcnt_nxt == r_blen);

    rd_tmo_cnt #(
        .TMO_W (TMO_W)
    ) u_tmo (
        .i_clk     (rclk),
        .i_rst_n   (rrst_n),
        .i_clr     (w_tmo_clr),
        .i_en      (w_tmo_en),
        .i_cfg_tmo (cfg_tmo),
        .o_hit     (w_tmo_hit)
    );

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_state      <= ST_IDLE;
            r_bcnt       <= '0;
            r_blen       <= '0;
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_rptr_clr   <= 1'b0;
            r_flush_done <= 1'b0;
            r_err        <= 1'b0;
            r_mrgn       <= '0;
        end else begin
            r_mrgn       <= cfg_mrgn;
            r_rptr_clr   <= 1'b0;
            r_flush_done <= 1'b0;

            if (w_rinc) begin
                r_m_data  <= rdata;
                r_m_valid <= 1'b1;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end

            if (under_flow) begin
                r_err <= 1'b1;
            end

            if (flush_req) begin
                // Any state, including an in-progress flush, restarts here.
                r_state    <= ST_FLUSH;
                r_rptr_clr <= 1'b1;
                r_m_valid  <= 1'b0;
                r_bcnt     <= '0;
                r_err      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_bcnt <= '0;
                        if (w_idle_go) begin
                            r_state <= ST_BURST;
                            r_blen  <= BLEN_W'(blen_eff(32'(cfg_blen)));
                        end
                    end
                    ST_BURST: begin
                        if (w_rinc) begin
                            if (w_burst_last) begin
                                r_state <= ST_IDLE;
                                r_bcnt  <= '0;
                            end else begin
                                r_bcnt <= w_bcnt_nxt;
                            end
                        end else if (empty) begin
                            // FIFO ran dry before the programmed length.
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_FLUSH: begin
                        r_state      <= ST_FLUSH_WAIT;
                        r_flush_done <= 1'b1;
                    end
                    ST_FLUSH_WAIT: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef FIFO_RD_CTRL_STATS_EN
    logic [31:0] r_stat_words;
    logic [15:0] r_stat_uflow;

    always_ff @(posedge rclk) begin
        if (!rrst_n || flush_req) begin
            r_stat_words <= '0;
            r_stat_uflow <= '0;
        end else begin
            if (w_rinc) begin
                r_stat_words <= r_stat_words + 32'd1;
            end
            if (under_flow && (r_stat_uflow != '1)) begin
                r_stat_uflow <= r_stat_uflow + 16'd1;
            end
        end
    end

    assign stat_words = r_stat_words;
    assign stat_uflow = r_stat_uflow;
`endif

    assign rinc            = w_rinc;
    assign rptr_clr        = r_rptr_clr;
    assign flush_done      = r_flush_done;
    assign near_empty_mrgn = r_mrgn;
    assign m_valid         = r_m_valid;
    assign m_data          = r_m_data;
    assign busy            = (r_state != ST_IDLE);
    assign err             = r_err;

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side burst scheduler for the asynchronous FIFO, in the read clock domain. Decides when to pop (`rinc`) and how many entries to pop, and forwards popped words to a valid/ready consumer through a one-entry output register. Opens a burst when occupancy is healthy or a partial-drain timeout expires. Also sequences pointer flushes (`rptr_clr`), drives the near-empty margin, and latches underflow errors.

## Interface
- `DSIZE`, 8: data word width.
- `ASIZE`, 4: FIFO address width; depth is 2^ASIZE.
- `BLEN_W`, 5: width of burst length; must satisfy BLEN_W >= ASIZE+1.
- `TMO_W`, 8: width of partial-drain timeout counter.
- `rclk` in 1: read clock. One clock only.
- `rrst_n` in 1: reset, synchronous, active-low.
- `empty` in 1: FIFO empty flag, registered.
- `near_empty` in 1: FIFO near-empty flag, registered.
- `under_flow` in 1: FIFO underflow pulse, registered.
- `rdata` in DSIZE: FIFO word at the current read address. Valid in the same cycle whenever `empty`=0.
- `rinc` out 1: pop strobe; combinational.
- `rptr_clr` out 1: read-pointer clear; registered.
- `near_empty_mrgn` out ASIZE+1: registered copy of `cfg_mrgn`.
- `cfg_mrgn` in ASIZE+1: near-empty margin.
- `cfg_blen` in BLEN_W: words per burst; 0 is treated as 1.
- `cfg_tmo` in TMO_W: idle cycles before a partial drain; 0 disables the timeout.
- `flush_req` in 1: flush request pulse.
- `flush_done` out 1: one-cycle pulse when a flush completes.
- `m_valid` out 1, `m_ready` in 1, `m_data` out DSIZE: consumer handshake.
- `busy` out 1: high when state is not IDLE.
- `err` out 1: sticky underflow flag.

## Operation
- FSM states: IDLE, BURST, FLUSH, FLUSH_WAIT.
- IDLE:
  - Go to BURST when `empty`=0 and `near_empty`=0.
  - Also go to BURST when `empty`=0 and the timeout counter equals `cfg_tmo` (`cfg_tmo` != 0).
  - The timeout counter increments while in IDLE with `empty`=0. It clears on leaving IDLE and whenever `empty`=1.
- BURST:
  - `rinc` = (state==BURST) & ~`empty` & (~`m_valid` | `m_ready`).
  - On each `rinc` cycle, `m_data` <= `rdata`, `m_valid` <= 1, burst counter +1.
  - `m_valid` clears on `m_ready` when no new pop happens in that cycle.
  - Return to IDLE when the burst counter reaches max(`cfg_blen`,1), or when `empty`=1 with no pop in that cycle (short burst).
- FLUSH:
  - Entered from any state on `flush_req`; flush has top priority.
  - `rptr_clr`=1 for exactly this cycle.
  - `m_valid` cleared, counters cleared, `err` cleared.
  - `rinc`=0.
- FLUSH_WAIT:
  - Lasts one cycle, while the FIFO flags resettle.
  - `rinc`=0.
  - `flush_done` pulses, then go to IDLE.
- `err` sets on `under_flow`=1 and holds until a flush or reset.
- `rinc` is never asserted while `empty`=1, so `under_flow` can only come from external misuse.
- `cfg_*` inputs are sampled at burst start. `near_empty_mrgn` tracks `cfg_mrgn` every cycle.
- Burst counter is BLEN_W bits and saturates at the compare value; no wrap.
- The timeout counter saturates at all-ones.

## Timing
- Reset values:
  - state=IDLE.
  - `rptr_clr`=0, `flush_done`=0, `m_valid`=0, `m_data`=0, `err`=0, `busy`=0.
  - `near_empty_mrgn`=0, all counters=0.
  - Reset asserted mid-burst aborts on the next edge and loses the word held in `m_data`.
- Pop-to-valid latency is 1 cycle: `m_valid` rises on the edge that advances the pointer.
- Throughput is 1 word/cycle while `m_ready`=1 and `empty`=0.
- Combinational paths: `m_ready` -> `rinc` and `empty` -> `rinc`.
- IDLE -> BURST takes 1 cycle after the condition is seen, so the first `rinc` comes one cycle after `empty` and `near_empty` are both low.
- `flush_req` is accepted on any edge:
  - `rptr_clr` high in the next cycle.
  - `flush_done` one cycle after that.
  - `flush_req` during FLUSH or FLUSH_WAIT restarts FLUSH.
- `flush_req` and a pop in the same cycle: the flush wins and `rinc` is forced 0 in that cycle.

## Configuration
- `FIFO_RD_CTRL_STATS_EN` defined: adds output `stat_words` (32 bits) and output `stat_uflow` (16 bits).
  - `stat_words` counts `rinc` pulses and wraps.
  - `stat_uflow` counts `under_flow` pulses and saturates.
  - Both clear on reset and on flush.
- Macro undefined: neither port nor either counter exists.

## Structure
- Package `fifo_ctrl_pkg`: state enum `rd_state_t`, the default width constants, and the `blen_eff` rule (0 maps to 1).
- Sub-module `rd_tmo_cnt` holds the saturating timeout counter: clear, enable, compare to `cfg_tmo`, `hit` output.

## Test plan
- Reset, FIFO flags `empty`=0, `near_empty`=0, `cfg_blen`=4, `m_ready`=1 -> exactly 4 consecutive `rinc` pulses, 4 `m_valid` words in order, then IDLE.
- `near_empty`=1 with 2 words queued, `cfg_tmo`=10 -> no `rinc` for 10 cycles, then a burst of 2 that ends early on `empty`.
- Mid-burst `m_ready` toggled 1,0,0,1 -> `rinc` low during stall, `m_data` held stable, no word lost or duplicated.
- `flush_req` in the 2nd cycle of an 8-word burst -> `rptr_clr` one cycle, `m_valid`=0, `flush_done` 1 cycle later, `err` cleared.
- External `under_flow` pulse -> `err`=1 held through 3 bursts; cleared only by flush; `stat_uflow`=1 when `FIFO_RD_CTRL_STATS_EN` is defined.
- `cfg_blen`=0 -> single-word bursts; `cfg_tmo`=0 with `near_empty`=1 -> no pops ever.
